// File: rtl/lc3b_l1_cache.sv
// Two-way set-associative, write-back, write-allocate L1 cache for the LC-3b memory port.
// 8 sets of 16-byte lines; whole-line fills and evictions over a req/resp pmem handshake.
module lc3b_l1_cache (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    state_e       state_q, state_d;
    logic         victim_q, victim_d;
    logic [1:0]   valid_q [8];
    logic [1:0]   valid_d [8];
    logic [1:0]   dirty_q [8];
    logic [1:0]   dirty_d [8];
    logic [7:0]   lru_q, lru_d;
    logic [8:0]   tag_q [8][2];
    logic [8:0]   tag_d [8][2];
    logic [127:0] data_q [8][2];
    logic [127:0] data_d [8][2];

    logic [2:0]   idx;
    logic [8:0]   tag;
    logic [6:0]   woff;
    logic         hit0, hit1, hit, hit_way, victim_sel, req;
    logic [127:0] hit_line, merged_line;
    logic [15:0]  hit_word, merged_word;
    logic         unused_addr_bit0;

    always_comb begin
        idx              = mem_address[6:4];
        tag              = mem_address[15:7];
        woff             = {mem_address[3:1], 4'b0000};
        unused_addr_bit0 = mem_address[0];
        hit0             = valid_q[idx][0] && (tag_q[idx][0] == tag);
        hit1             = valid_q[idx][1] && (tag_q[idx][1] == tag);
        hit              = hit0 | hit1;
        hit_way          = !hit0;
        hit_line         = data_q[idx][hit_way];
        hit_word         = hit_line[woff +: 16];
        merged_word      = hit_word;
        if (mem_byte_enable[0]) merged_word[7:0] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_word[15:8] = mem_wdata[15:8];
        merged_line              = hit_line;
        merged_line[woff +: 16]  = merged_word;
        // Invalid ways fill first (way0 before way1); otherwise the LRU way.
        if (!valid_q[idx][0]) begin
            victim_sel = 1'b0;
        end else if (!valid_q[idx][1]) begin
            victim_sel = 1'b1;
        end else begin
            victim_sel = lru_q[idx];
        end
        req = mem_read | mem_write;
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        lru_d        = lru_q;
        tag_d        = tag_q;
        data_d       = data_q;
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_address = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (hit) begin
                        mem_resp        = 1'b1;
                        mem_rdata       = hit_word;
                        lru_d[idx]      = ~hit_way;
                        if (mem_write && (mem_byte_enable != 2'b00)) begin
                            data_d[idx][hit_way]  = merged_line;
                            dirty_d[idx][hit_way] = 1'b1;
                        end
                    end else begin
                        victim_d = victim_sel;
                        if (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) begin
                            state_d = StWriteback;
                        end else begin
                            state_d = StAllocate;
                        end
                    end
                end
            end
            StWriteback: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx][victim_q], idx, 4'b0000};
                pmem_wdata   = data_q[idx][victim_q];
                if (pmem_resp) begin
                    dirty_d[idx][victim_q] = 1'b0;
                    state_d                = StAllocate;
                end
            end
            StAllocate: begin
                pmem_read    = 1'b1;
                pmem_address = {tag, idx, 4'b0000};
                if (pmem_resp) begin
                    data_d[idx][victim_q]  = pmem_rdata;
                    tag_d[idx][victim_q]   = tag;
                    valid_d[idx][victim_q] = 1'b1;
                    dirty_d[idx][victim_q] = 1'b0;
                    state_d                = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            victim_q <= 1'b0;
            lru_q    <= 8'h00;
            for (int s = 0; s < 8; s++) begin
                valid_q[s] <= 2'b00;
                dirty_q[s] <= 2'b00;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            lru_q    <= lru_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
        end
    end

    // Tags and data are left as-is by reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end
endmodule
